// File: rtl/byte_pair_word_assembler.sv
// Packs a valid/ready byte stream into WIDTH-bit words held in a 2-entry output FIFO.
// A flush emits a half-assembled word zero-padded and tagged via word_pad.
module byte_pair_word_assembler #(
    parameter int unsigned BYTE_W    = 8,
    parameter int unsigned WIDTH     = 16,
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned DEPTH     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              flush,
    output logic [WIDTH-1:0]  word_out,
    output logic              word_pad,
    output logic              word_valid,
    input  logic              word_ready
);

    typedef enum logic [0:0] {StEmpty, StHalf} state_e;

    localparam logic [1:0] CountFull = 2'(DEPTH);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] hold_q, hold_d;
    logic              flush_pend_q, flush_pend_d;
    logic              byte_ready_q, byte_ready_d;
    logic [WIDTH:0]    mem_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q, count_d;
    logic              byte_acc, pop, push, fifo_full;
    logic [WIDTH:0]    push_entry;

    function automatic logic [WIDTH-1:0] pack(input logic [BYTE_W-1:0] first,
                                              input logic [BYTE_W-1:0] second);
        if (LSB_FIRST) begin
            return {second, first};
        end else begin
            return {first, second};
        end
    endfunction

    assign byte_acc   = byte_valid && byte_ready_q;
    assign fifo_full  = (count_q == CountFull);
    assign word_valid = (count_q != 2'd0);
    assign pop        = word_valid && word_ready;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        flush_pend_d = flush_pend_q;
        push         = 1'b0;
        push_entry   = '0;
        unique case (state_q)
            StEmpty: begin
                if (byte_acc) begin
                    hold_d  = byte_in;
                    state_d = StHalf;
                end
            end
            StHalf: begin
                // An accepted byte always beats a simultaneous or pending flush.
                if (byte_acc) begin
                    push         = 1'b1;
                    push_entry   = {1'b0, pack(hold_q, byte_in)};
                    state_d      = StEmpty;
                    flush_pend_d = 1'b0;
                end else if (flush || flush_pend_q) begin
                    if (!fifo_full) begin
                        push         = 1'b1;
                        push_entry   = {1'b1, pack(hold_q, '0)};
                        state_d      = StEmpty;
                        flush_pend_d = 1'b0;
                    end else begin
                        flush_pend_d = 1'b1;
                    end
                end
            end
            default: state_d = StEmpty;
        endcase
        count_d      = count_q + 2'(push) - 2'(pop);
        // Ready depends only on the next registered state, never on word_ready directly.
        byte_ready_d = (state_d == StEmpty) || (count_d < CountFull);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StEmpty;
            hold_q       <= '0;
            flush_pend_q <= 1'b0;
            byte_ready_q <= 1'b1;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            mem_q[0]     <= '0;
            mem_q[1]     <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            flush_pend_q <= flush_pend_d;
            byte_ready_q <= byte_ready_d;
            count_q      <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
            end
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop;
        end
    end

    assign byte_ready = byte_ready_q;
    assign word_out   = mem_q[rd_ptr_q][WIDTH-1:0];
    assign word_pad   = mem_q[rd_ptr_q][WIDTH];

    assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop))
        else $error("push into full output FIFO");

    assert property (@(posedge clk) disable iff (rst) count_q <= CountFull)
        else $error("output FIFO count out of range");

endmodule

// File: tb/tb_byte_pair_word_assembler.sv
// Bench for byte_pair_word_assembler: vector table, hand sequences for reset,
// and a random run against a queue-based reference model.
module tb_byte_pair_word_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a_byte, b_byte;
    logic        a_bv, b_bv, a_fl, b_fl, a_wr, b_wr;
    logic        a_br, b_br, a_wv, b_wv, a_pad, b_pad;
    logic [15:0] a_wo, b_wo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    byte_pair_word_assembler #(.BYTE_W(8), .WIDTH(16), .LSB_FIRST(1'b1), .DEPTH(2)) u_lsb (
        .clk(clk), .rst(rst), .byte_in(a_byte), .byte_valid(a_bv), .byte_ready(a_br),
        .flush(a_fl), .word_out(a_wo), .word_pad(a_pad), .word_valid(a_wv), .word_ready(a_wr)
    );

    byte_pair_word_assembler #(.BYTE_W(8), .WIDTH(16), .LSB_FIRST(1'b0), .DEPTH(2)) u_msb (
        .clk(clk), .rst(rst), .byte_in(b_byte), .byte_valid(b_bv), .byte_ready(b_br),
        .flush(b_fl), .word_out(b_wo), .word_pad(b_pad), .word_valid(b_wv), .word_ready(b_wr)
    );

    typedef struct {
        bit          sel;
        logic        bv;
        logic [7:0]  b;
        logic        fl;
        logic        wr;
        logic        ebr;
        logic        ewv;
        logic [15:0] ewo;
        logic        epad;
    } vec_t;

    vec_t vecs[$];

    // reference model state
    bit          m_have;
    logic [7:0]  m_held;
    bit          m_pend;
    logic [16:0] m_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(bit sel, logic bv, logic [7:0] b, logic fl, logic wr,
                                logic ebr, logic ewv, logic [15:0] ewo, logic epad);
        vec_t v;
        v.sel = sel; v.bv = bv; v.b = b; v.fl = fl; v.wr = wr;
        v.ebr = ebr; v.ewv = ewv; v.ewo = ewo; v.epad = epad;
        vecs.push_back(v);
    endfunction

    task automatic idle_inputs();
        a_bv = 1'b0; a_byte = 8'h00; a_fl = 1'b0; a_wr = 1'b0;
        b_bv = 1'b0; b_byte = 8'h00; b_fl = 1'b0; b_wr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge: check outputs, drive inputs, advance to the next negedge.
    task automatic apply_vec(input vec_t v, input int idx);
        logic        br, wv, pad;
        logic [15:0] wo;
        br  = v.sel ? b_br  : a_br;
        wv  = v.sel ? b_wv  : a_wv;
        wo  = v.sel ? b_wo  : a_wo;
        pad = v.sel ? b_pad : a_pad;
        chk($sformatf("vec%0d byte_ready", idx), 32'(br), 32'(v.ebr));
        chk($sformatf("vec%0d word_valid", idx), 32'(wv), 32'(v.ewv));
        if (v.ewv) begin
            chk($sformatf("vec%0d word_out", idx), 32'(wo), 32'(v.ewo));
            chk($sformatf("vec%0d word_pad", idx), 32'(pad), 32'(v.epad));
        end
        idle_inputs();
        if (v.sel) begin
            b_bv = v.bv; b_byte = v.b; b_fl = v.fl; b_wr = v.wr;
        end else begin
            a_bv = v.bv; a_byte = v.b; a_fl = v.fl; a_wr = v.wr;
        end
        @(negedge clk);
    endtask

    task automatic drive_a(input logic bv, input logic [7:0] b, input logic fl, input logic wr);
        a_bv = bv; a_byte = b; a_fl = fl; a_wr = wr;
        @(negedge clk);
    endtask

    function automatic void model_step(logic bv, logic [7:0] b, logic fl, logic wr);
        bit acc;
        int sz;
        acc = bv && (!m_have || m_q.size() < 2);
        sz  = m_q.size();
        if (sz > 0 && wr) void'(m_q.pop_front());
        if (!m_have) begin
            if (acc) begin
                m_have = 1'b1;
                m_held = b;
            end
        end else if (acc) begin
            m_q.push_back({1'b0, b, m_held});
            m_have = 1'b0;
            m_pend = 1'b0;
        end else if (fl || m_pend) begin
            if (sz < 2) begin
                m_q.push_back({1'b1, 8'h00, m_held});
                m_have = 1'b0;
                m_pend = 1'b0;
            end else begin
                m_pend = 1'b1;
            end
        end
    endfunction

    initial begin
        // LSB-first streaming, consumer always ready
        add(0, 1, 8'h34, 0, 1, 1, 0, 16'h0000, 0);
        add(0, 1, 8'h12, 0, 1, 1, 0, 16'h0000, 0);
        add(0, 1, 8'hCD, 0, 1, 1, 1, 16'h1234, 0);
        add(0, 1, 8'hAB, 0, 1, 1, 0, 16'h0000, 0);
        add(0, 0, 8'h00, 0, 1, 1, 1, 16'hABCD, 0);
        add(0, 0, 8'h00, 0, 1, 1, 0, 16'h0000, 0);
        // consumer stalled: FIFO fills, ready drops in HALF, then drains in order
        add(0, 1, 8'h01, 0, 0, 1, 0, 16'h0000, 0);
        add(0, 1, 8'h02, 0, 0, 1, 0, 16'h0000, 0);
        add(0, 1, 8'h03, 0, 0, 1, 1, 16'h0201, 0);
        add(0, 1, 8'h04, 0, 0, 1, 1, 16'h0201, 0);
        add(0, 1, 8'h05, 0, 0, 1, 1, 16'h0201, 0);
        add(0, 1, 8'h06, 0, 0, 0, 1, 16'h0201, 0);
        add(0, 1, 8'h06, 0, 1, 0, 1, 16'h0201, 0);
        add(0, 1, 8'h06, 0, 1, 1, 1, 16'h0403, 0);
        add(0, 0, 8'h00, 0, 1, 1, 1, 16'h0605, 0);
        add(0, 0, 8'h00, 0, 0, 1, 0, 16'h0000, 0);
        // flush against a full FIFO becomes pending, completes after one pop
        add(0, 1, 8'hA1, 0, 0, 1, 0, 16'h0000, 0);
        add(0, 1, 8'hA2, 0, 0, 1, 0, 16'h0000, 0);
        add(0, 1, 8'hB1, 0, 0, 1, 1, 16'hA2A1, 0);
        add(0, 1, 8'hB2, 0, 0, 1, 1, 16'hA2A1, 0);
        add(0, 1, 8'h77, 0, 0, 1, 1, 16'hA2A1, 0);
        add(0, 0, 8'h00, 1, 0, 0, 1, 16'hA2A1, 0);
        add(0, 0, 8'h00, 0, 0, 0, 1, 16'hA2A1, 0);
        add(0, 0, 8'h00, 0, 1, 0, 1, 16'hA2A1, 0);
        add(0, 0, 8'h00, 0, 0, 1, 1, 16'hB2B1, 0);
        add(0, 0, 8'h00, 0, 1, 1, 1, 16'hB2B1, 0);
        add(0, 0, 8'h00, 0, 1, 1, 1, 16'h0077, 1);
        add(0, 0, 8'h00, 0, 0, 1, 0, 16'h0000, 0);
        // byte beats simultaneous flush; flush in EMPTY is ignored
        add(0, 1, 8'h11, 0, 1, 1, 0, 16'h0000, 0);
        add(0, 1, 8'h22, 1, 1, 1, 0, 16'h0000, 0);
        add(0, 0, 8'h00, 0, 1, 1, 1, 16'h2211, 0);
        add(0, 0, 8'h00, 0, 1, 1, 0, 16'h0000, 0);
        add(0, 0, 8'h00, 1, 1, 1, 0, 16'h0000, 0);
        add(0, 0, 8'h00, 0, 1, 1, 0, 16'h0000, 0);
        // MSB-first packing and padded flush
        add(1, 1, 8'h12, 0, 1, 1, 0, 16'h0000, 0);
        add(1, 1, 8'h34, 0, 1, 1, 0, 16'h0000, 0);
        add(1, 0, 8'h00, 0, 1, 1, 1, 16'h1234, 0);
        add(1, 1, 8'h5A, 0, 1, 1, 0, 16'h0000, 0);
        add(1, 0, 8'h00, 1, 1, 1, 0, 16'h0000, 0);
        add(1, 0, 8'h00, 0, 1, 1, 1, 16'h5A00, 1);
        add(1, 0, 8'h00, 0, 1, 1, 0, 16'h0000, 0);

        do_reset();
        chk("reset a word_out", 32'(a_wo), 32'h0);
        chk("reset a word_pad", 32'(a_pad), 32'h0);
        chk("reset b word_out", 32'(b_wo), 32'h0);
        chk("reset b word_valid", 32'(b_wv), 32'h0);
        chk("reset b byte_ready", 32'(b_br), 32'h1);
        foreach (vecs[i]) apply_vec(vecs[i], i);

        // asynchronous reset with a held byte and a full FIFO
        drive_a(1'b1, 8'hC1, 1'b0, 1'b0);
        drive_a(1'b1, 8'hC2, 1'b0, 1'b0);
        drive_a(1'b1, 8'hD1, 1'b0, 1'b0);
        drive_a(1'b1, 8'hD2, 1'b0, 1'b0);
        drive_a(1'b1, 8'hE1, 1'b0, 1'b0);
        a_bv = 1'b0;
        chk("pre-reset word_valid", 32'(a_wv), 32'h1);
        chk("pre-reset byte_ready", 32'(a_br), 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("async reset word_valid", 32'(a_wv), 32'h0);
        chk("async reset byte_ready", 32'(a_br), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        drive_a(1'b1, 8'hEF, 1'b0, 1'b1);
        drive_a(1'b1, 8'hBE, 1'b0, 1'b1);
        a_bv = 1'b0;
        chk("post-reset word_valid", 32'(a_wv), 32'h1);
        chk("post-reset word_out", 32'(a_wo), 32'hBEEF);
        chk("post-reset word_pad", 32'(a_pad), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post-reset drained %0d", i), 32'(a_wv), 32'h0);
        end

        // random traffic against the reference model
        do_reset();
        m_have = 1'b0;
        m_held = 8'h00;
        m_pend = 1'b0;
        m_q.delete();
        for (int i = 0; i < 600; i++) begin
            logic       bv, fl, wr;
            logic [7:0] b;
            chk($sformatf("rnd%0d byte_ready", i), 32'(a_br),
                32'(!m_have || m_q.size() < 2));
            chk($sformatf("rnd%0d word_valid", i), 32'(a_wv), 32'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                chk($sformatf("rnd%0d head", i), 32'({a_pad, a_wo}), 32'(m_q[0]));
            end
            bv = ($urandom_range(0, 9) < 7);
            b  = 8'($urandom);
            fl = ($urandom_range(0, 9) < 2);
            wr = ($urandom_range(0, 9) < 5);
            model_step(bv, b, fl, wr);
            drive_a(bv, b, fl, wr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
